// File: rtl/object_sched_pkg.sv
// object_sched_pkg: coordinate widths, scan FSM states and object descriptor layout.
package object_sched_pkg;
    localparam int ROW_W = 9;
    localparam int COL_W = 10;
    localparam logic [ROW_W-1:0] ROW_LIMIT = 9'd480;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    typedef struct packed {
        logic             vis;
        logic [ROW_W-1:0] px;
        logic [COL_W-1:0] py;
        logic [COL_W-1:0] w;
        logic [ROW_W-1:0] h;
    } obj_t;
endpackage

// File: rtl/span_check.sv
// span_check: 1-D interval test lo <= p < lo+len, end computed one bit wider so it never wraps.
module span_check #(
    parameter int W = 9
) (
    input  logic [W-1:0] p,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] len,
    output logic         covered
);
    assign covered = (p >= lo) && ({1'b0, p} < ({1'b0, lo} + {1'b0, len}));
endmodule

// File: rtl/object_scheduler.sv
// object_scheduler: per-line sprite selection with serial table scan and 1-cycle pixel hit test.
// Optional OBJSCHED_COLLIDE_EN enables the registered multi-object collide flag.
module object_scheduler
    import object_sched_pkg::*;
#(
    parameter int N_OBJ  = 8,
    parameter int N_LINE = 4,
    parameter int COLW   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(N_OBJ)-1:0] wr_idx,
    input  logic [8:0]               wr_Px,
    input  logic [9:0]               wr_Py,
    input  logic [9:0]               wr_W,
    input  logic [8:0]               wr_H,
    input  logic [COLW-1:0]          wr_color,
    input  logic                     wr_vis,
    input  logic                     frame_start,
    input  logic                     line_start,
    input  logic [8:0]               next_row,
    input  logic                     pix_valid,
    input  logic [8:0]               x_pos,
    input  logic [9:0]               y_pos,
    output logic                     busy,
    output logic                     hit,
    output logic [$clog2(N_OBJ)-1:0] hit_idx,
    output logic [COLW-1:0]          hit_color,
    output logic                     overflow,
    output logic                     collide
);
    localparam int IW = $clog2(N_OBJ);
    localparam int CW = $clog2(N_LINE + 1);

    state_t state, state_nx;
    obj_t            shadow [N_OBJ];
    obj_t            active [N_OBJ];
    logic [COLW-1:0] sh_col [N_OBJ];
    logic [COLW-1:0] ac_col [N_OBJ];
    logic            pend_commit;

    logic [ROW_W-1:0] row_r;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic             row_in, row_hit, pend_ovf;
    logic             do_commit, copy;

    logic [N_LINE-1:0] pend_v, live_v, col_in, cov;
    logic [IW-1:0]     pend_idx [N_LINE];
    logic [IW-1:0]     live_idx [N_LINE];
    logic [COL_W-1:0]  pend_py  [N_LINE];
    logic [COL_W-1:0]  live_py  [N_LINE];
    logic [COL_W-1:0]  pend_w   [N_LINE];
    logic [COL_W-1:0]  live_w   [N_LINE];
    logic [COLW-1:0]   pend_col [N_LINE];
    logic [COLW-1:0]   live_col [N_LINE];

    logic [IW-1:0]   win_idx;
    logic [COLW-1:0] win_col;
    logic            pix_ok;

    assign busy      = (state != IDLE);
    assign do_commit = (state == COMMIT) && !line_start;
    assign copy      = (frame_start && !busy) || (do_commit && (pend_commit || frame_start));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        if (line_start) state_nx = SCAN;
        else if (state == SCAN) state_nx = (idx == '1) ? COMMIT : SCAN;
        else if (state == COMMIT) state_nx = IDLE;
    end

    // A copy reads the pre-edge shadow, so a same-cycle write waits for the next commit.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < N_OBJ; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
                sh_col[i] <= '0;
                ac_col[i] <= '0;
            end
            pend_commit <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow[wr_idx] <= '{vis: wr_vis, px: wr_Px, py: wr_Py, w: wr_W, h: wr_H};
                sh_col[wr_idx] <= wr_color;
            end
            if (copy) begin
                active <= shadow;
                ac_col <= sh_col;
            end
            pend_commit <= do_commit ? 1'b0 : (pend_commit || (frame_start && busy));
        end

    span_check #(.W(ROW_W)) u_row (
        .p(row_r), .lo(active[idx].px), .len(active[idx].h), .covered(row_in)
    );
    assign row_hit = active[idx].vis && row_in;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            row_r    <= '0;
            idx      <= '0;
            cnt      <= '0;
            pend_ovf <= 1'b0;
            overflow <= 1'b0;
            pend_v   <= '0;
            live_v   <= '0;
            for (int s = 0; s < N_LINE; s++) begin
                pend_idx[s] <= '0;
                pend_py[s]  <= '0;
                pend_w[s]   <= '0;
                pend_col[s] <= '0;
                live_idx[s] <= '0;
                live_py[s]  <= '0;
                live_w[s]   <= '0;
                live_col[s] <= '0;
            end
        end else begin
            if (line_start) begin
                row_r    <= next_row;
                idx      <= '0;
                cnt      <= '0;
                pend_v   <= '0;
                pend_ovf <= 1'b0;
            end else if (state == SCAN) begin
                idx <= idx + IW'(1);
                if (row_hit && cnt == CW'(N_LINE)) pend_ovf <= 1'b1;
                if (row_hit && cnt < CW'(N_LINE)) cnt <= cnt + CW'(1);
                for (int s = 0; s < N_LINE; s++)
                    if (row_hit && cnt == CW'(s)) begin
                        pend_v[s]   <= 1'b1;
                        pend_idx[s] <= idx;
                        pend_py[s]  <= active[idx].py;
                        pend_w[s]   <= active[idx].w;
                        pend_col[s] <= ac_col[idx];
                    end
            end
            if (do_commit) begin
                live_v   <= pend_v;
                live_idx <= pend_idx;
                live_py  <= pend_py;
                live_w   <= pend_w;
                live_col <= pend_col;
                overflow <= pend_ovf;
            end
        end

    for (genvar g = 0; g < N_LINE; g++) begin : g_col
        span_check #(.W(COL_W)) u_col (
            .p(y_pos), .lo(live_py[g]), .len(live_w[g]), .covered(col_in[g])
        );
    end
    assign cov    = live_v & col_in;
    assign pix_ok = pix_valid && (x_pos < ROW_LIMIT);

    // Descending walk leaves the lowest covering slot as the winner.
    always_comb begin
        win_idx = '0;
        win_col = '0;
        for (int s = N_LINE - 1; s >= 0; s--)
            if (cov[s]) begin
                win_idx = live_idx[s];
                win_col = live_col[s];
            end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hit       <= 1'b0;
            hit_idx   <= '0;
            hit_color <= '0;
        end else begin
            hit <= pix_ok && (|cov);
            if (pix_ok && (|cov)) begin
                hit_idx   <= win_idx;
                hit_color <= win_col;
            end
        end

`ifdef OBJSCHED_COLLIDE_EN
    logic [CW-1:0] n_cov;
    always_comb begin
        n_cov = '0;
        for (int s = 0; s < N_LINE; s++) n_cov = n_cov + CW'(cov[s]);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) collide <= 1'b0;
        else        collide <= pix_ok && (n_cov >= CW'(2));
`else
    assign collide = 1'b0;
`endif
endmodule
